ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; sends command bytes (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Drives the same ps2_clk/ps2_data lines that the ps2_keyboard receiver samples, through open-drain enables.
//  Runs on the system clock and oversamples the device-generated PS/2 clock.
//  Provides a start/busy/done/err handshake to the top level.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles ps2_clk is held low before the request (100us at 50MHz)
//  TIMEOUT_CYCLES  750000  watchdog limit in clk cycles, counted from the start of REQ (15ms at 50MHz)
// PORTS
//  clk          in   1  system clock; all logic on its rising edge
//  clrn         in   1  synchronous reset, active low
//  start        in   1  one-cycle request; accepted only when busy=0
//  din          in   8  byte to send; captured on the accepted start cycle
//  ps2_clk_in   in   1  sensed PS/2 clock line (asynchronous)
//  ps2_data_in  in   1  sensed PS/2 data line (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release
//  ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
//  busy         out  1  high from the cycle after an accepted start until done/err
//  done         out  1  one-cycle pulse: byte sent and ACK received
//  err          out  1  one-cycle pulse: missing ACK or watchdog expiry
// BEHAVIOUR
//  - Reset (clrn=0 at a clk edge): all outputs 0 and state=IDLE. Mid-frame reset releases both lines on the next edge.
//  - ps2_clk_in and ps2_data_in pass through 3-flop synchronisers.
//  - fall = sync_clk[2] & ~sync_clk[1], a one-cycle pulse per PS/2 falling edge.
//  - Shift register {parity, din}: parity = ~^din (odd parity).
//  - Bit counter cnt counts 0..10.
//  - IDLE: accepted start latches din; next state INHIBIT.
//  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then data_oe=1 (start bit).
//    One cycle later clk_oe=0 and the FSM enters REQ.
//  - REQ/DATA:
//    - fall with cnt=0..7: data_oe = ~din[cnt].
//    - cnt=8: data_oe = ~parity.
//    - cnt=9: data_oe=0 (stop bit).
//    - cnt increments on each fall.
//  - ACK: on the fall with cnt=10, sample sync_data.
//    - 0 -> WAIT_IDLE.
//    - 1 -> err pulse, then IDLE.
//  - WAIT_IDLE: wait until both synced lines are 1, then pulse done and return to IDLE.
//  - done/err assert together with busy falling. start in that same cycle is ignored.
//  - start while busy=1 is ignored; din is not re-captured.
//  - ps2_clk_oe and ps2_data_oe are never both changed by the INHIBIT exit in the same cycle (order fixed above).
//  - Inhibit counter width: $clog2(INHIBIT_CYCLES+1). Watchdog width: $clog2(TIMEOUT_CYCLES+1).
// CONFIGURATION
//  PS2_TX_TIMEOUT_EN defined:
//   - The watchdog runs in REQ..WAIT_IDLE.
//   - On expiry: err pulse, both oe=0, return to IDLE (device absent or stuck).
//  Undefined:
//   - No watchdog logic is synthesised; the FSM waits indefinitely for device clocks.
//   - err comes only from a missing ACK.
// TESTING
//  - Reset: clrn=0 for 2 cycles with start=1 -> busy=done=err=0, both oe=0.
//  - Send 0xED through a device model (10-20kHz clock, ACK low):
//    - clk_oe low for 5000 cycles, then start bit 0.
//    - Sampled bits 1,0,1,1,0,1,1,1, then parity 1 and stop 1.
//    - done=1 for one cycle; busy falls in the same cycle.
//  - Send 0x01 -> parity bit 0. Send 0xFF -> parity bit 1. Both end with a done pulse.
//  - Device holds data high at the ACK edge -> err pulse, done stays 0, FSM returns to IDLE.
//  - start pulsed again during DATA with din=0x55 -> ignored; the original byte completes unchanged.
//  - Mid-frame reset at cnt=4 -> both oe=0 next edge; a following 0xF4 send completes normally.
//  - PS2_TX_TIMEOUT_EN defined, no device clocks -> err pulse 750000 cycles after REQ entry.
//    Undefined -> busy stays 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain clock/data enables.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a frame when the device stops clocking.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 750000
`endif
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, REQ, WAIT_IDLE} state_t;
    state_t state, state_n;
    logic [2:0] sync_clk, sync_data;
    logic [8:0] sr, sr_n;
    logic [3:0] cnt, cnt_n;
    logic [IW-1:0] icnt, icnt_n;
    logic clk_oe_n, data_oe_n, busy_n, done_n, err_n;
    logic fall, wd_exp;
    assign fall = sync_clk[2] & ~sync_clk[1];
`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wcnt;
    always_ff @(posedge clk)
        if (!clrn || state < REQ) wcnt <= '0;
        else wcnt <= wcnt + 1'b1;
    assign wd_exp = (state >= REQ) && (wcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_exp = 1'b0;
`endif
    always_ff @(posedge clk) begin
        sync_clk <= {sync_clk[1:0], ps2_clk_in};
        sync_data <= {sync_data[1:0], ps2_data_in};
        if (!clrn) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            icnt <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            sr <= sr_n;
            cnt <= cnt_n;
            icnt <= icnt_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            busy <= busy_n;
            done <= done_n;
            err <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        sr_n = sr;
        cnt_n = cnt;
        icnt_n = icnt;
        clk_oe_n = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        busy_n = busy;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: if (start && !done && !err) begin
                state_n = INHIBIT;
                sr_n = {~^din, din};
                cnt_n = '0;
                icnt_n = '0;
                clk_oe_n = 1'b1;
                data_oe_n = 1'b0;
                busy_n = 1'b1;
            end
            INHIBIT: begin
                icnt_n = icnt + 1'b1;
                if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_n = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                clk_oe_n = 1'b0;
                state_n = REQ;
            end
            // ones shifted in behind the parity bit release the line for the stop bit
            REQ: if (fall) begin
                cnt_n = cnt + 1'b1;
                if (cnt == 4'd10) begin
                    state_n = sync_data[2] ? IDLE : WAIT_IDLE;
                    err_n = sync_data[2];
                    busy_n = ~sync_data[2];
                end else begin
                    data_oe_n = ~sr[0];
                    sr_n = {1'b1, sr[8:1]};
                end
            end
            WAIT_IDLE: if (sync_clk[2] && sync_data[2]) begin
                done_n = 1'b1;
                busy_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (wd_exp) begin
            state_n = IDLE;
            err_n = 1'b1;
            busy_n = 1'b0;
            clk_oe_n = 1'b0;
            data_oe_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven bench with a PS/2 device model and an expected-frame scoreboard.
module tb_ps2_host_tx;
    localparam int INH = 5000;
    localparam int TMO = 3000;
    localparam int H = 20;
    typedef struct {
        logic [7:0] d;
        logic       ack;
        logic [9:0] frame;
        logic       ed;
        logic       ee;
    } vec_t;
    typedef struct {
        logic [9:0] frame;
        logic       ed;
        logic       ee;
    } exp_t;
    logic clk = 1'b0;
    logic clrn, start, dclk_low, ddat_low;
    logic [7:0] din;
    logic ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic ps2_clk_in, ps2_data_in;
    int checks = 0, errors = 0;
    int done_cnt = 0, err_cnt = 0, pulse_bad = 0;
    logic busy_q = 1'b0, pulse_q = 1'b0;
    exp_t expq[$];
    vec_t vecs[5];
    assign ps2_clk_in = ~(ps2_clk_oe | dclk_low);
    assign ps2_data_in = ~(ps2_data_oe | ddat_low);
    always #5 clk = ~clk;
    ps2_host_tx #(
        .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
       ,.TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk), .clrn(clrn), .start(start), .din(din),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .err(err)
    );
    // a done/err pulse must be one cycle wide and coincide with busy falling
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if ((done === 1'b1 || err === 1'b1) && (busy !== 1'b0 || busy_q !== 1'b1 || pulse_q)) pulse_bad++;
        busy_q = busy;
        pulse_q = (done === 1'b1) || (err === 1'b1);
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] d, input logic ack, input int mode,
                        input logic [9:0] ef, input logic ed, input logic ee);
        int n, d0, e0, p0;
        logic [9:0] got;
        exp_t x;
        got = '0;
        if (mode < 2) expq.push_back('{ef, ed, ee});
        @(negedge clk);
        din = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din = 8'h00;
        d0 = done_cnt;
        e0 = err_cnt;
        p0 = pulse_bad;
        chk("busy_rise", busy, 1);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 100) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
        chk("start_overlap", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        @(negedge clk);
        chk("req_start_bit", {ps2_clk_oe, ps2_data_in}, 2'b00);
        if (mode == 3) begin
`ifdef PS2_TX_TIMEOUT_EN
            n = 0;
            while (err !== 1'b1 && n < TMO + 200) begin
                @(negedge clk);
                n++;
            end
            chk("wd_latency", n, TMO);
            chk("wd_release", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
            repeat (2) @(negedge clk);
            chk("wd_err_cnt", err_cnt - e0, 1);
            chk("wd_done_cnt", done_cnt - d0, 0);
`else
            repeat (TMO + 200) @(negedge clk);
            chk("no_wd_busy", {busy, ps2_clk_oe}, 2'b10);
            chk("no_wd_err", err_cnt - e0, 0);
            clrn = 1'b0;
            @(negedge clk);
            clrn = 1'b1;
            chk("no_wd_reset", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
`endif
            return;
        end
        for (int i = 0; i < 10; i++) begin
            repeat (H) @(negedge clk);
            if (mode == 2 && i == 4) begin
                clrn = 1'b0;
                @(negedge clk);
                clrn = 1'b1;
                chk("reset_release", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
                repeat (H) @(negedge clk);
                return;
            end
            dclk_low = 1'b1;
            if (mode == 1 && i == 4) begin
                start = 1'b1;
                din = 8'h55;
            end
            @(negedge clk);
            start = 1'b0;
            repeat (H - 1) @(negedge clk);
            dclk_low = 1'b0;
            got[i] = ps2_data_in;
        end
        repeat (H / 2) @(negedge clk);
        ddat_low = ack;
        repeat (H / 2) @(negedge clk);
        dclk_low = 1'b1;
        repeat (H) @(negedge clk);
        dclk_low = 1'b0;
        repeat (H / 2) @(negedge clk);
        ddat_low = 1'b0;
        n = 0;
        while (done_cnt + err_cnt == d0 + e0 && done !== 1'b1 && err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done === 1'b1 || err === 1'b1) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("start_ignored_at_end", busy, 0);
        x = expq.pop_front();
        chk("frame", got, x.frame);
        chk("done_cnt", done_cnt - d0, x.ed);
        chk("err_cnt", err_cnt - e0, x.ee);
        chk("pulse_shape", pulse_bad - p0, 0);
    endtask
    initial begin
        vecs[0] = '{8'hED, 1'b1, 10'b11_11101101, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 10'b10_00000001, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 10'b11_11111111, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 1'b0, 10'b11_10100101, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 10'b11_00000000, 1'b1, 1'b0};
        clrn = 1'b0;
        start = 1'b1;
        din = 8'hED;
        dclk_low = 1'b0;
        ddat_low = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        clrn = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        foreach (vecs[i]) send(vecs[i].d, vecs[i].ack, 0, vecs[i].frame, vecs[i].ed, vecs[i].ee);
        send(8'h3C, 1'b1, 1, 10'b11_00111100, 1'b1, 1'b0);
        send(8'h81, 1'b1, 2, 10'b0, 1'b0, 1'b0);
        send(8'hF4, 1'b1, 0, 10'b10_11110100, 1'b1, 1'b0);
        send(8'h12, 1'b1, 3, 10'b0, 1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
